// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 transmitter: a byte FIFO feeds an 11-bit frame serialiser that drives
// ps2_clk/ps2_data, with host-inhibit abort and whole-frame retry.
module ps2_kbd_tx #(
  parameter int CLK_DIV = 2500,
  parameter int GAP_CYC = 5000,
  parameter int DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   inhibit,
  output logic                   ps2_clk,
  output logic                   ps2_data,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW      = $clog2(DEPTH);
  localparam int LW      = AW + 1;
  localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_GAP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      idx, idx_n;
  logic [10:0]     frame, frame_n;
  logic            retry, retry_n;
  logic [LW-1:0]   level_n;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [7:0]      mem [DEPTH];
  logic [7:0]      head;
  logic            push, pop, try_start, drive;

  assign push  = in_valid & in_ready;
  assign head  = mem[rd_ptr];
  assign drive = ((state == S_HIGH) || (state == S_LOW)) && !inhibit;

  // NOTE: storage array has no reset; emptiness is tracked by the pointers and level only.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // NOTE: every next-state value gets its default first so no path leaves it unassigned.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    frame_n   = frame;
    retry_n   = retry;
    try_start = 1'b0;
    pop       = 1'b0;
    unique case (state)
      S_IDLE: try_start = 1'b1;
      S_HIGH, S_LOW: begin
        if (inhibit) begin
          // Host grabbed the clock: a frame cut during its stop bit still counts as sent.
          state_n = S_GAP;
          cnt_n   = '0;
          retry_n = (idx != 4'd10);
        end else if (cnt == CW'(CLK_DIV - 1)) begin
          cnt_n = '0;
          if (state == S_HIGH) begin
            state_n = S_LOW;
          end else if (idx == 4'd10) begin
            state_n = S_GAP;
          end else begin
            state_n = S_HIGH;
            idx_n   = idx + 4'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == CW'(GAP_CYC - 1)) begin
          // Fold the idle decision into the last gap cycle so back-to-back frames are
          // separated by exactly GAP_CYC idle cycles on the lines.
          state_n   = S_IDLE;
          cnt_n     = '0;
          try_start = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (try_start && (retry || (level != '0)) && !inhibit) begin
      state_n = S_HIGH;
      cnt_n   = '0;
      idx_n   = '0;
      retry_n = 1'b0;
      if (!retry) begin
        frame_n = {1'b1, ~^head, head, 1'b0};
        pop     = 1'b1;
      end
    end
  end

  always_comb begin
    level_n = level;
    if (push && !pop)      level_n = level + 1'b1;
    else if (!push && pop) level_n = level - 1'b1;
  end

  // NOTE: all state and output registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      frame    <= '1;
      retry    <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      frame    <= frame_n;
      retry    <= retry_n;
      level    <= level_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      in_ready <= (level_n < LW'(DEPTH));
      busy     <= (state_n != S_IDLE) || (level_n != '0) || retry_n;
      // Lines follow the current phase one edge later; inhibit forces them idle at once.
      ps2_clk  <= !((state == S_LOW) && !inhibit);
      ps2_data <= drive ? frame[idx] : 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: a line-level PS/2 receiver model decodes frames from ps2_clk/ps2_data
// and a byte scoreboard checks them against pushed bytes, plus cycle-exact corner sequences.
module tb_ps2_kbd_tx;
  localparam int CLK_DIV = 4;
  localparam int GAP_CYC = 8;
  localparam int DEPTH   = 8;
  localparam int LW      = $clog2(DEPTH) + 1;
  localparam int N_RAND  = 40;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          inhibit = 1'b0;
  logic          in_ready, ps2_clk, ps2_data, busy;
  logic [LW-1:0] level;

  ps2_kbd_tx #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .inhibit(inhibit), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  int pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Receiver model: collects bits at ps2_clk falling edges; a run of idle line longer than a
  // half-period ends a partial (aborted) frame.
  typedef struct { logic [10:0] bits; int n; bit full10; } rx_frame_t;
  rx_frame_t rx_q[$];
  int        gap_q[$];
  int        stab_err = 0;

  initial begin
    int bitcnt = 0, low_len = 0, idle_run = 0;
    bit last_full = 1'b0;
    logic [10:0] sh = '1;
    logic prev_clk = 1'b1, prev_data = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset) begin
        bitcnt = 0; low_len = 0; idle_run = 0;
      end else begin
        if (prev_clk && ps2_clk && prev_data && !ps2_data && bitcnt == 0) gap_q.push_back(idle_run);
        if (!prev_clk && !ps2_clk && (ps2_data != prev_data)) stab_err++;
        if (prev_clk && !ps2_clk) begin
          sh[bitcnt] = ps2_data;
          bitcnt++;
          low_len = 0;
        end
        if (!ps2_clk) low_len++;
        if (!prev_clk && ps2_clk) last_full = (low_len == CLK_DIV);
        idle_run = (ps2_clk && ps2_data) ? idle_run + 1 : 0;
        if (bitcnt == 11) begin
          rx_q.push_back('{sh, 11, 1'b1});
          bitcnt = 0;
        end else if (bitcnt != 0 && idle_run >= CLK_DIV + 2) begin
          rx_q.push_back('{sh, bitcnt, last_full});
          bitcnt = 0;
        end
      end
      prev_clk = ps2_clk;
      prev_data = ps2_data;
    end
  end

  logic [7:0] exp_q[$];
  int delivered = 0;
  int aborted   = 0;

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    int ones = $countones(d);
    return {1'b1, (ones % 2 == 0), d, 1'b0};
  endfunction

  // A frame counts as delivered when all 11 bits went out, or when only the stop bit was cut.
  task automatic score();
    rx_frame_t f;
    logic [10:0] mask, ef;
    while (rx_q.size() != 0) begin
      f = rx_q.pop_front();
      check("frame_has_pending_byte", exp_q.size() != 0, 1);
      if (exp_q.size() == 0) continue;
      ef   = frame_of(exp_q[0]);
      mask = 11'((12'd1 << f.n) - 12'd1);
      check($sformatf("frame_bits_%02h_n%0d", exp_q[0], f.n), f.bits & mask, ef & mask);
      if (f.n == 11 || (f.n == 10 && f.full10)) begin
        void'(exp_q.pop_front());
        delivered++;
      end else begin
        aborted++;
      end
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    int k = 0;
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (in_ready) exp_q.push_back(b);
    else check("push_accepted_in_time", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_quiet(input int budget);
    int k = 0;
    while ((busy || !ps2_clk || !ps2_data) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("quiet_within_budget", k < budget, 1);
    repeat (CLK_DIV + 4) @(negedge clk);
  endtask

  task automatic at_edge(input int t0, input int k);
    while (pcyc < t0 + k) @(negedge clk);
  endtask

  typedef struct { logic [7:0] data; logic parity; } vec_t;
  vec_t vecs[8];

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, d0, a0, acc;
    bit push_done;
    vecs[0] = '{8'h00, 1'b1}; vecs[1] = '{8'hFF, 1'b1};
    vecs[2] = '{8'h01, 1'b0}; vecs[3] = '{8'h80, 1'b0};
    vecs[4] = '{8'h55, 1'b1}; vecs[5] = '{8'hAA, 1'b1};
    vecs[6] = '{8'h7E, 1'b1}; vecs[7] = '{8'hE0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ps2_clk", ps2_clk, 1);
    check("rst_ps2_data", ps2_data, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 0x1C: latency, half-period, frame length and gap
    push_byte(8'h1C);
    t = pcyc;
    check("lat_t0_data_idle", ps2_data, 1);
    check("lat_t0_level", level, 1);
    at_edge(t, 1);  check("lat_t1_data_idle", ps2_data, 1);
    check("lat_t1_level_popped", level, 0);
    at_edge(t, 2);  check("lat_t2_start_bit", ps2_data, 0);
    check("lat_t2_clk_high", ps2_clk, 1);
    at_edge(t, 5);  check("lat_t5_clk_high", ps2_clk, 1);
    at_edge(t, 6);  check("lat_t6_clk_low", ps2_clk, 0);
    at_edge(t, 89); check("frame_last_low", ps2_clk, 0);
    at_edge(t, 90); check("gap_clk", ps2_clk, 1);
    check("gap_data", ps2_data, 1);
    check("gap_busy", busy, 1);
    at_edge(t, 96); check("gap_end_busy", busy, 1);
    at_edge(t, 97); check("idle_busy_low", busy, 0);
    repeat (4) @(negedge clk);
    check("1c_frame_count", rx_q.size(), 1);
    if (rx_q.size() != 0) check("1c_falling_edge_bits", rx_q[0].bits, 11'b100_0011_1000);
    score();

    // Back-to-back F0, 1C
    gap_q.delete();
    d0 = delivered;
    push_byte(8'hF0);
    push_byte(8'h1C);
    wait_quiet(600);
    check("b2b_frames", rx_q.size(), 2);
    if (rx_q.size() != 0) check("f0_parity", rx_q[0].bits[9], 1);
    check("b2b_gap_count", gap_q.size(), 2);
    if (gap_q.size() == 2) check("b2b_gap_len", gap_q[1], GAP_CYC);
    score();
    check("b2b_delivered", delivered - d0, 2);

    // Table of bytes with hand-derived parity
    for (int i = 0; i < 8; i++) begin
      push_byte(vecs[i].data);
      wait_quiet(300);
      check($sformatf("vec%0d_frames", i), rx_q.size(), 1);
      if (rx_q.size() != 0) begin
        check($sformatf("vec%0d_parity", i), rx_q[0].bits[9], vecs[i].parity);
        check($sformatf("vec%0d_data", i), rx_q[0].bits[8:1], vecs[i].data);
      end
      score();
    end

    // Fill while inhibited: only DEPTH accepted, lines idle
    d0 = delivered;
    inhibit = 1'b1;
    @(negedge clk);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(8'hA0 + i);
      in_valid = 1'b1;
      if (in_ready) begin
        exp_q.push_back(in_data);
        acc++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("fill_accepted", acc, DEPTH);
    check("fill_level", level, DEPTH);
    check("fill_in_ready", in_ready, 0);
    check("fill_lines_idle", {ps2_clk, ps2_data}, 2'b11);
    check("fill_busy", busy, 1);
    check("fill_no_frames", rx_q.size(), 0);
    inhibit = 1'b0;
    wait_quiet(DEPTH * 120 + 200);
    score();
    check("fill_delivered", delivered - d0, DEPTH);
    check("fill_level_drained", level, 0);

    // Inhibit during idx=4 LOW of 0x55 with 0x29 queued: resend 0x55 in full first
    d0 = delivered; a0 = aborted;
    push_byte(8'h55);
    t = pcyc;
    push_byte(8'h29);
    at_edge(t, 37); inhibit = 1'b1;
    at_edge(t, 38);
    check("inh_clk_high", ps2_clk, 1);
    check("inh_data_high", ps2_data, 1);
    check("inh_level", level, 1);
    check("inh_busy", busy, 1);
    repeat (20) @(negedge clk);
    inhibit = 1'b0;
    wait_quiet(600);
    score();
    check("inh_aborted", aborted - a0, 1);
    check("inh_delivered", delivered - d0, 2);
    check("inh_exp_empty", exp_q.size(), 0);

    // Inhibit during stop bit: treated as delivered, no resend
    d0 = delivered; a0 = aborted;
    push_byte(8'h12);
    t = pcyc;
    at_edge(t, 82); inhibit = 1'b1;
    at_edge(t, 83);
    check("stop_inh_lines", {ps2_clk, ps2_data}, 2'b11);
    at_edge(t, 84); inhibit = 1'b0;
    at_edge(t, 92);
    check("stop_inh_no_retry", busy, 0);
    repeat (200) @(negedge clk);
    score();
    check("stop_inh_delivered", delivered - d0, 1);
    check("stop_inh_no_abort", aborted - a0, 0);

    // Reset mid-frame at idx=6 with another byte queued
    push_byte(8'h77);
    t = pcyc;
    push_byte(8'h66);
    at_edge(t, 50);
    check("prerst_level", level, 1);
    reset = 1'b0;
    at_edge(t, 51);
    check("midrst_clk", ps2_clk, 1);
    check("midrst_data", ps2_data, 1);
    check("midrst_level", level, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    rx_q.delete();
    repeat (300) @(negedge clk);
    check("postrst_no_frames", rx_q.size(), 0);
    check("postrst_busy", busy, 0);

    // Randomised pushes with random host-inhibit pulses
    d0 = delivered;
    push_done = 1'b0;
    fork
      begin
        for (int i = 0; i < N_RAND; i++) begin
          repeat (($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 150)) @(negedge clk);
          push_byte(8'($urandom()));
        end
        push_done = 1'b1;
      end
      begin
        while (!push_done) begin
          repeat ($urandom_range(20, 250)) @(negedge clk);
          if (!push_done) begin
            inhibit = 1'b1;
            repeat ($urandom_range(1, 12)) @(negedge clk);
            inhibit = 1'b0;
          end
        end
      end
    join
    inhibit = 1'b0;
    wait_quiet(20000);
    score();
    check("rand_delivered", delivered - d0, N_RAND);
    check("rand_exp_empty", exp_q.size(), 0);
    check("data_stable_while_clk_low", stab_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
